// File: rtl/cfg_packet_sequencer.sv
// Purpose: merges config packets from a strobe-only port and a valid/ready port onto one write bus.
// Latency: port-1 handshake to cfg_valid 1 cycle; port-0 strobe into an empty FIFO during DATA is 2 cycles.
// Backpressure: cfg_ready low holds the write; port 1 stalls via s1_ready; port 0 drops words when the FIFO is full.
`timescale 1ns/1ps

// Small synchronous FIFO. Purpose: buffer port-0 words.
// Latency: pushed word visible at the head next cycle.
// Backpressure: a push into a full FIFO is accepted only with a same-cycle pop.
module cfg_packet_sequencer_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         pop_ok;
  logic         push_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer update; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

module cfg_packet_sequencer #(
  parameter logic [7:0] SYNC       = 8'hC5,
  parameter int         FIFO_DEPTH = 2,
  parameter int         TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_abort,
  input  logic        s0_strobe,
  input  logic [31:0] s0_data,
  input  logic        s1_valid,
  input  logic [31:0] s1_data,
  output logic        s1_ready,
  output logic        cfg_valid,
  output logic [15:0] cfg_addr,
  output logic [31:0] cfg_data,
  input  logic        cfg_ready,
  output logic        busy,
  output logic        grant,
  output logic        done,
  output logic        err_sync,
  output logic        err_timeout,
  output logic        err_ovf
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_t;

  state_t        state, state_nxt;
  logic          grant_nxt;
  logic          ptr, ptr_nxt;
  logic          done_nxt, sync_nxt, to_nxt;

  logic [31:0]   fifo_rdata;
  logic          fifo_empty, fifo_full, fifo_pop;

  logic          out_vld;
  logic [15:0]   addr_cnt;
  logic [7:0]    rem;
  logic [TW-1:0] tcnt;

  logic          src_vld;
  logic [31:0]   src_dat;
  logic          pop_ok, accept, stall, take, to_hit, ovf_now;

  cfg_packet_sequencer_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (cfg_abort),
    .push  (s0_strobe && !cfg_abort),
    .pop   (fifo_pop),
    .wdata (s0_data),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign src_vld   = grant ? s1_valid : !fifo_empty;
  assign src_dat   = grant ? s1_data  : fifo_rdata;
  assign pop_ok    = !out_vld || cfg_ready;
  assign accept    = out_vld && cfg_ready;
  assign stall     = out_vld && !cfg_ready;
  assign busy      = (state != ST_IDLE);
  assign cfg_valid = out_vld;

  // Source pop and port-1 ready; s1_ready never looks at s1_valid.
  always_comb begin
    take     = 1'b0;
    s1_ready = 1'b0;
    case (state)
      ST_HDR: begin
        take     = src_vld;
        s1_ready = grant;
      end
      ST_DATA: begin
        take     = src_vld && (rem != 8'd0) && pop_ok;
        s1_ready = grant && (rem != 8'd0) && pop_ok;
      end
      default: ;
    endcase
  end

  assign fifo_pop = take && !grant;
  assign to_hit   = busy && !take && !accept && !stall && (tcnt == TW'(TIMEOUT - 1));
  // A strobe is lost only when the FIFO is full and nothing leaves this cycle.
  assign ovf_now  = s0_strobe && !cfg_abort && fifo_full && !fifo_pop;

  // Control state register plus registered status pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      grant       <= 1'b0;
      ptr         <= 1'b0;
      done        <= 1'b0;
      err_sync    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      ptr         <= ptr_nxt;
      done        <= done_nxt;
      err_sync    <= sync_nxt;
      err_timeout <= to_nxt;
    end
  end

  // Next state: arbitration in IDLE, header check, end-of-packet and timeout.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    sync_nxt  = 1'b0;
    to_nxt    = 1'b0;
    if (cfg_abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty || s1_valid) begin
            grant_nxt = s1_valid && (fifo_empty || ptr);
            state_nxt = ST_HDR;
          end
        end
        ST_HDR: begin
          if (to_hit) begin
            to_nxt    = 1'b1;
            ptr_nxt   = !grant;
            state_nxt = ST_IDLE;
          end else if (take) begin
            if (src_dat[31:24] != SYNC) begin
              sync_nxt  = 1'b1;
              state_nxt = ST_IDLE;
            end else if (src_dat[23:16] == 8'd0) begin
              done_nxt  = 1'b1;
              ptr_nxt   = !grant;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (to_hit) begin
            to_nxt    = 1'b1;
            ptr_nxt   = !grant;
            state_nxt = ST_IDLE;
          end else if (accept && (rem == 8'd0)) begin
            done_nxt  = 1'b1;
            ptr_nxt   = !grant;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath: output register, address/remaining counters, idle timer, overflow pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_vld  <= 1'b0;
      cfg_addr <= '0;
      cfg_data <= '0;
      addr_cnt <= '0;
      rem      <= '0;
      tcnt     <= '0;
      err_ovf  <= 1'b0;
    end else begin
      err_ovf <= ovf_now;
      if (cfg_abort || state == ST_IDLE || to_hit) begin
        out_vld <= 1'b0;
        tcnt    <= '0;
      end else begin
        if (take || accept) tcnt <= '0;
        else if (!stall)    tcnt <= tcnt + TW'(1);
        if (state == ST_HDR) begin
          if (take) begin
            addr_cnt <= src_dat[15:0];
            rem      <= src_dat[23:16];
          end
        end else begin
          if (take) begin
            out_vld  <= 1'b1;
            cfg_addr <= addr_cnt;
            cfg_data <= src_dat;
            addr_cnt <= addr_cnt + 16'd1;
            rem      <= rem - 8'd1;
          end else if (accept) begin
            out_vld <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_cfg_packet_sequencer.sv
// Purpose: scoreboard bench for cfg_packet_sequencer with directed packets on both ports.
// Latency: expected writes are queued at stimulus time and retired by the monitor on acceptance.
// Backpressure: bench drives cfg_ready low for stall, overflow and abort scenarios.
`timescale 1ns/1ps

module tb_cfg_packet_sequencer;
  logic        clk = 1'b0;
  logic        reset, cfg_abort, s0_strobe, s1_valid, cfg_ready;
  logic [31:0] s0_data, s1_data;
  logic        s1_ready, cfg_valid, busy, grant, done, err_sync, err_timeout, err_ovf;
  logic [15:0] cfg_addr;
  logic [31:0] cfg_data;

  always #5 clk = ~clk;

  cfg_packet_sequencer #(.SYNC(8'hC5), .FIFO_DEPTH(2), .TIMEOUT(1024)) dut (
    .clk(clk), .reset(reset), .cfg_abort(cfg_abort),
    .s0_strobe(s0_strobe), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .busy(busy), .grant(grant), .done(done), .err_sync(err_sync),
    .err_timeout(err_timeout), .err_ovf(err_ovf)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          done_cnt = 0, sync_cnt = 0, to_cnt = 0, ovf_cnt = 0;
  logic        stalled = 1'b0;
  logic [15:0] st_a;
  logic [31:0] st_d;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: retires accepted writes, checks stall stability and port-1 hold-off.
  always @(negedge clk) begin
    if (reset) begin
      if (done)        done_cnt++;
      if (err_sync)    sync_cnt++;
      if (err_timeout) to_cnt++;
      if (err_ovf)     ovf_cnt++;
      if (cfg_valid && stalled) begin
        check("stall_addr", cfg_addr, st_a);
        check("stall_data", cfg_data, st_d);
      end
      stalled = cfg_valid && !cfg_ready;
      st_a    = cfg_addr;
      st_d    = cfg_data;
      if (cfg_valid && cfg_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected none", cfg_addr, cfg_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", cfg_addr, e.a);
          check("wr_data", cfg_data, e.d);
        end
      end
      if (busy && !grant) check("s1_ready_hold", s1_ready, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s0_word(input logic [31:0] w);
    s0_strobe = 1'b1;
    s0_data   = w;
    tick();
    s0_strobe = 1'b0;
  endtask

  task automatic s1_word(input logic [31:0] w);
    bit got;
    got      = 1'b0;
    s1_valid = 1'b1;
    s1_data  = w;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (s1_ready) got = 1'b1;
      tick();
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL s1_handshake: got no s1_ready, expected handshake for %0h", w);
    end
  endtask

  task automatic wait_quiet(input int limit);
    bit q;
    q = 1'b0;
    for (int i = 0; i < limit && !q; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) q = 1'b1;
    end
    check("quiet", q, 1'b1);
    tick();
  endtask

  task automatic wait_cfg_valid(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (cfg_valid) seen = 1'b1;
    end
    check("cfg_valid_seen", seen, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int d0, s0c, t0c, o0c, n;
    bit hit;
    reset = 1'b0; cfg_abort = 1'b0; s0_strobe = 1'b0; s0_data = '0;
    s1_valid = 1'b0; s1_data = '0; cfg_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_cfg_valid", cfg_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, 1'b0);
    check("rst_s1_ready", s1_ready, 1'b0);
    check("rst_pulses", {done, err_sync, err_timeout, err_ovf}, 4'b0);
    tick();
    reset = 1'b1;
    tick();

    // Both ports pending together with pointer 0: port 0 goes first.
    d0 = done_cnt;
    expect_wr(16'h0200, 32'h1111_1111); expect_wr(16'h0201, 32'h2222_2222);
    expect_wr(16'h0300, 32'h3333_3333); expect_wr(16'h0301, 32'h4444_4444);
    fork
      begin s0_word(32'hC502_0200); s0_word(32'h1111_1111); s0_word(32'h2222_2222); end
      begin tick(); s1_word(32'hC502_0300); s1_word(32'h3333_3333); s1_word(32'h4444_4444); s1_valid = 1'b0; end
    join
    wait_quiet(200);
    check("done_both", done_cnt - d0, 2);

    // Port 0 alone, three words.
    d0 = done_cnt;
    expect_wr(16'h0010, 32'h0A0A_0A0A); expect_wr(16'h0011, 32'h0B0B_0B0B); expect_wr(16'h0012, 32'h0C0C_0C0C);
    s0_word(32'hC503_0010); s0_word(32'h0A0A_0A0A); s0_word(32'h0B0B_0B0B); s0_word(32'h0C0C_0C0C);
    wait_quiet(200);
    check("done_p0", done_cnt - d0, 1);

    // Pointer now 1: a simultaneous request is won by port 1.
    expect_wr(16'h0400, 32'h5555_5555); expect_wr(16'h0500, 32'h6666_6666);
    fork
      begin s0_word(32'hC501_0500); s0_word(32'h6666_6666); end
      begin tick(); s1_word(32'hC501_0400); s1_word(32'h5555_5555); s1_valid = 1'b0; end
    join
    wait_quiet(200);

    // Address wrap with a 5-cycle stall on the first write.
    d0 = done_cnt; t0c = to_cnt;
    cfg_ready = 1'b0;
    expect_wr(16'hFFFF, 32'h7777_7777); expect_wr(16'h0000, 32'h8888_8888);
    fork
      begin s1_word(32'hC502_FFFF); s1_word(32'h7777_7777); s1_word(32'h8888_8888); s1_valid = 1'b0; end
      begin
        wait_cfg_valid(100);
        check("stall_first_addr", cfg_addr, 16'hFFFF);
        check("stall_first_data", cfg_data, 32'h7777_7777);
        repeat (5) tick();
        cfg_ready = 1'b1;
      end
    join
    wait_quiet(200);
    check("wrap_done", done_cnt - d0, 1);
    check("wrap_no_timeout", to_cnt - t0c, 0);

    // Bad sync byte is dropped, the next packet from port 0 goes through.
    d0 = done_cnt; s0c = sync_cnt;
    expect_wr(16'h0600, 32'h9999_9999);
    s0_word(32'h3A01_0000); s0_word(32'hC501_0600); s0_word(32'h9999_9999);
    wait_quiet(200);
    check("sync_err", sync_cnt - s0c, 1);
    check("sync_done", done_cnt - d0, 1);

    // Truncated packet times out after about 1024 idle cycles.
    d0 = done_cnt; t0c = to_cnt;
    expect_wr(16'h0100, 32'hAAAA_AAAA);
    s0_word(32'hC504_0100); s0_word(32'hAAAA_AAAA);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    n = 0; hit = 1'b0;
    for (int i = 0; i < 1500 && !hit; i++) begin
      @(negedge clk);
      n++;
      if (err_timeout) hit = 1'b1;
    end
    check("timeout_seen", hit, 1'b1);
    check("timeout_window", (n >= 1015 && n <= 1035), 1'b1);
    check("timeout_busy", busy, 1'b0);
    tick();
    check("timeout_cnt", to_cnt - t0c, 1);
    check("timeout_no_done", done_cnt - d0, 0);

    // Overflow on the third strobe while stalled, then abort mid-packet.
    d0 = done_cnt; o0c = ovf_cnt; s0c = sync_cnt;
    cfg_ready = 1'b0;
    s0_word(32'hC504_0700); s0_word(32'hD0D0_D0D0);
    wait_cfg_valid(50);
    tick();
    s0_word(32'hE1E1_E1E1); s0_word(32'hE2E2_E2E2); s0_word(32'hE3E3_E3E3);
    @(negedge clk);
    check("ovf_pulse", err_ovf, 1'b1);
    tick();
    cfg_abort = 1'b1; s0_strobe = 1'b1; s0_data = 32'hC501_0800;
    tick();
    cfg_abort = 1'b0; s0_strobe = 1'b0; cfg_ready = 1'b1;
    @(negedge clk);
    check("abort_cfg_valid", cfg_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (5) tick();
    @(negedge clk);
    check("abort_fifo_empty", busy, 1'b0);
    check("ovf_cnt", ovf_cnt - o0c, 1);
    tick();

    // Clean packet after the abort proves the FIFO was flushed.
    expect_wr(16'h0900, 32'h1234_5678);
    s0_word(32'hC501_0900); s0_word(32'h1234_5678);
    wait_quiet(200);
    check("post_abort_sync", sync_cnt - s0c, 0);
    check("post_abort_done", done_cnt - d0, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cfg_packet_sequencer.md
Name: cfg_packet_sequencer

Overview:
- Sequences configuration packets from two requesters onto a single shared config-register write bus.
- Port 0 is the JTAG config shifter's word stream: strobe-only, no backpressure.
- Port 1 is a valid/ready host port.
- Packet-granular round-robin arbitration, header check, address auto-increment, per-word output handshake, inactivity timeout and abort.

Parameters:
- SYNC, 8'hC5, required header sync byte.
- FIFO_DEPTH, 2, port-0 word buffer depth (power of 2, ≥2).
- TIMEOUT, 1024, max idle cycles between words of a granted packet before abort (≥64).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  reset, synchronous, active-low.
- cfg_abort  in  1  synchronous abort; wired to the shifter's reset output.
- s0_strobe  in  1  port-0 word valid, single-cycle pulse.
- s0_data  in  32  port-0 word.
- s1_valid  in  1  port-1 word valid.
- s1_data  in  32  port-1 word.
- s1_ready  out  1  port-1 accept.
- cfg_valid  out  1  write request on config bus.
- cfg_addr  out  16  write address.
- cfg_data  out  32  write data.
- cfg_ready  in  1  config bus accepts the current write.
- busy  out  1  state != IDLE.
- grant  out  1  requester owning the current packet.
- done  out  1  1-cycle pulse, packet completed.
- err_sync  out  1  1-cycle pulse, bad header dropped.
- err_timeout  out  1  1-cycle pulse, packet aborted by timeout.
- err_ovf  out  1  1-cycle pulse, port-0 word lost.

Behaviour:
- Reset (reset==0 at an edge):
  - All outputs 0; s1_ready 0.
  - FIFO emptied; state IDLE; priority pointer 0; counters 0.
- Packet format:
  - Header word: [31:24] must equal SYNC; [23:16] count N (0..255); [15:0] start address.
  - N data words follow.
- Port-0 FIFO:
  - Push on s0_strobe.
  - Full and no pop in the same cycle: word discarded, err_ovf pulse next cycle.
  - Full with simultaneous push and pop: legal, no error.
- States:
  - IDLE:
    - If the FIFO is non-empty and/or s1_valid is high, register grant and go to HDR.
    - Both pending: grant the port the pointer selects. Pointer 0 selects port 0.
    - No arbitration occurs mid-packet.
  - HDR: pop one word from the granted source. Port 1 pops via s1_ready=1 with s1_valid.
    - Sync mismatch: word dropped, err_sync pulse, go to IDLE, pointer unchanged.
    - N==0: done pulse, pointer = ~grant, go to IDLE.
    - Otherwise: load addr counter = [15:0], remaining = N, go to DATA.
  - DATA:
    - Pop a word from the granted source only when the output register is empty or cfg_ready is high this cycle.
    - Popped word is presented next cycle: cfg_valid=1, cfg_data=word, cfg_addr=addr counter.
    - Addr increments per pop; 16'hFFFF wraps to 0.
    - cfg_valid/cfg_addr/cfg_data stay stable until cfg_ready is sampled high.
    - After the last word is accepted (cfg_valid & cfg_ready): done pulse, pointer = ~grant, go to IDLE.
- s1_ready:
  - Combinational from state, grant and output-register occupancy only; never depends on s1_valid.
  - 1 in HDR with grant==1.
  - 1 in DATA with grant==1, remaining>0, and the pop condition true.
  - 0 otherwise.
- Timeout:
  - In HDR/DATA, the counter resets on each pop and on each cfg_ready acceptance, and increments otherwise.
  - At TIMEOUT: err_timeout pulse, cfg_valid dropped, go to IDLE, pointer = ~grant.
  - Stall caused by cfg_ready low with cfg_valid high does not count.
- cfg_abort:
  - Priority below reset and above everything else.
  - Next cycle: IDLE, cfg_valid=0 (pending write discarded), FIFO flushed, no done, pointer kept.
  - s0_strobe in the abort cycle is discarded.
- Latency:
  - Port-1 handshake to cfg_valid: 1 cycle.
  - Port-0 strobe into empty FIFO while in DATA: cfg_valid 2 cycles later.
- Errors are mutually exclusive per cycle except err_ovf, which may coincide with any other error.

Test Plan:
- Port 0 only: header C5_03_0010 then words A,B,C, cfg_ready=1 → three writes to 0010/0011/0012 with data A/B/C, one done pulse, pointer=1.
- Both ports request in the same cycle, each sending a 2-word packet, pointer=0 → port-0 packet fully written before any port-1 word. s1_ready stays 0 until port 0's done; then port-1 packet is written.
- Header C5_02_FFFF with cfg_ready held low 5 cycles on the first write → addr/data stable for the stall, no timeout; addresses FFFF then 0000.
- Header 3A_01_0000 → err_sync pulse, no cfg_valid; a following valid packet from the same port is written normally.
- Header C5_04_0100 then only 1 data word, no further input → one write to 0100, then err_timeout after 1024 idle cycles, busy=0.
- Three s0 strobes on consecutive cycles while DATA is stalled on cfg_ready=0 (FIFO_DEPTH=2) → err_ovf on the third. Then cfg_abort mid-packet → cfg_valid=0, FIFO empty, no done the next cycle.
